// File: rtl/rv32_bus_pkg.sv
// Shared bus definitions: arbiter state encoding and the byte-enable mask type,
// also used by the memory stage.
package rv32_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INSTR = 2'd1,
    DATA  = 2'd2
  } bus_state_t;

  typedef logic [3:0] byte_mask_t;

endpackage

// File: rtl/rv32_bus_timeout.sv
// Bus timeout down-counter: loads TIMEOUT_CYCLES on grant, counts down on every
// cycle the slave is not ready, and flags expiry at zero.
module rv32_bus_timeout #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_load,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= CW'(TIMEOUT_CYCLES);
    end else if (i_enable && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_expired = (r_count == '0);

endmodule

// File: rtl/rv32_bus_arbiter.sv
// Two-master (fetch / memory stage) to one-slave bus arbiter, data has fixed priority.
// Optional slave timeout fault enabled by defining RV32_BUS_TIMEOUT_EN.
import rv32_bus_pkg::*;

module rv32_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] instr_address_in,
  input  logic        instr_read_in,
  output logic [31:0] instr_read_value_out,
  output logic        instr_ready_out,
  output logic        instr_fault_out,
  input  logic [31:0] data_address_in,
  input  logic        data_read_in,
  input  logic        data_write_in,
  input  byte_mask_t  data_write_mask_in,
  input  logic [31:0] data_write_value_in,
  output logic [31:0] data_read_value_out,
  output logic        data_ready_out,
  output logic        data_fault_out,
  output logic [31:0] bus_address_out,
  output logic        bus_read_out,
  output logic        bus_write_out,
  output byte_mask_t  bus_write_mask_out,
  output logic [31:0] bus_write_value_out,
  input  logic [31:0] bus_read_value_in,
  input  logic        bus_ready_in
);

  bus_state_t  r_state;
  logic [31:0] r_bus_address;
  logic        r_bus_read;
  logic        r_bus_write;
  byte_mask_t  r_bus_mask;
  logic [31:0] r_bus_value;

  logic w_data_req;
  logic w_grant;
  logic w_busy;
  logic w_expired;
  logic w_done;

  assign w_data_req = data_read_in | data_write_in;
  assign w_grant    = (r_state == IDLE) && (w_data_req || instr_read_in);
  assign w_busy     = (r_state != IDLE);
  assign w_done     = bus_ready_in | w_expired;

`ifdef RV32_BUS_TIMEOUT_EN
  logic w_count_zero;

  rv32_bus_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_load   (w_grant),
    .i_enable (w_busy && !bus_ready_in),
    .o_expired(w_count_zero)
  );

  assign w_expired = w_busy && w_count_zero;
`else
  // Never true for a legal TIMEOUT_CYCLES; the arbiter waits on the slave indefinitely.
  assign w_expired = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_bus_address <= '0;
      r_bus_read    <= 1'b0;
      r_bus_write   <= 1'b0;
      r_bus_mask    <= '0;
      r_bus_value   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          // Data beats fetch; a simultaneous read+write request is a write.
          if (w_data_req) begin
            r_state       <= DATA;
            r_bus_address <= data_address_in;
            r_bus_read    <= !data_write_in;
            r_bus_write   <= data_write_in;
            r_bus_mask    <= data_write_in ? data_write_mask_in : '0;
            r_bus_value   <= data_write_value_in;
          end else if (instr_read_in) begin
            r_state       <= INSTR;
            r_bus_address <= instr_address_in;
            r_bus_read    <= 1'b1;
            r_bus_write   <= 1'b0;
            r_bus_mask    <= '0;
            r_bus_value   <= '0;
          end
        end
        INSTR, DATA: begin
          if (w_done) begin
            r_state     <= IDLE;
            r_bus_read  <= 1'b0;
            r_bus_write <= 1'b0;
            r_bus_mask  <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus_address_out     = r_bus_address;
  assign bus_read_out        = r_bus_read;
  assign bus_write_out       = r_bus_write;
  assign bus_write_mask_out  = r_bus_mask;
  assign bus_write_value_out = r_bus_value;

  // Ready is gated by the live request so a flushed master never sees a pulse.
  assign instr_ready_out      = (r_state == INSTR) && w_done && instr_read_in;
  assign instr_fault_out      = instr_ready_out && !bus_ready_in;
  assign instr_read_value_out = (instr_ready_out && bus_ready_in) ? bus_read_value_in : '0;

  assign data_ready_out      = (r_state == DATA) && w_done && w_data_req;
  assign data_fault_out      = data_ready_out && !bus_ready_in;
  assign data_read_value_out = (data_ready_out && bus_ready_in) ? bus_read_value_in : '0;

endmodule

// File: tb/tb_rv32_bus_arbiter.sv
// Directed bench for rv32_bus_arbiter; inputs change on the falling edge and
// outputs are checked 1 ns later, well away from the rising edge.
`timescale 1ns/1ps
module tb_rv32_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] instr_address_in;
  logic        instr_read_in;
  logic [31:0] instr_read_value_out;
  logic        instr_ready_out;
  logic        instr_fault_out;
  logic [31:0] data_address_in;
  logic        data_read_in;
  logic        data_write_in;
  logic [3:0]  data_write_mask_in;
  logic [31:0] data_write_value_in;
  logic [31:0] data_read_value_out;
  logic        data_ready_out;
  logic        data_fault_out;
  logic [31:0] bus_address_out;
  logic        bus_read_out;
  logic        bus_write_out;
  logic [3:0]  bus_write_mask_out;
  logic [31:0] bus_write_value_out;
  logic [31:0] bus_read_value_in;
  logic        bus_ready_in;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rv32_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .instr_address_in    (instr_address_in),
    .instr_read_in       (instr_read_in),
    .instr_read_value_out(instr_read_value_out),
    .instr_ready_out     (instr_ready_out),
    .instr_fault_out     (instr_fault_out),
    .data_address_in     (data_address_in),
    .data_read_in        (data_read_in),
    .data_write_in       (data_write_in),
    .data_write_mask_in  (data_write_mask_in),
    .data_write_value_in (data_write_value_in),
    .data_read_value_out (data_read_value_out),
    .data_ready_out      (data_ready_out),
    .data_fault_out      (data_fault_out),
    .bus_address_out     (bus_address_out),
    .bus_read_out        (bus_read_out),
    .bus_write_out       (bus_write_out),
    .bus_write_mask_out  (bus_write_mask_out),
    .bus_write_value_out (bus_write_value_out),
    .bus_read_value_in   (bus_read_value_in),
    .bus_ready_in        (bus_ready_in)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step_cycle();
    @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " bus_read"},  32'(bus_read_out), 32'd0);
    check({tag, " bus_write"}, 32'(bus_write_out), 32'd0);
    check({tag, " i_ready"},   32'(instr_ready_out), 32'd0);
    check({tag, " d_ready"},   32'(data_ready_out), 32'd0);
  endtask

  initial begin
    reset_n             = 1'b0;
    instr_address_in    = '0;
    instr_read_in       = 1'b0;
    data_address_in     = '0;
    data_read_in        = 1'b0;
    data_write_in       = 1'b0;
    data_write_mask_in  = '0;
    data_write_value_in = '0;
    bus_read_value_in   = '0;
    bus_ready_in        = 1'b0;

    // Reset state
    step_cycle(); #1;
    check_idle_outputs("rst");
    check("rst addr",  bus_address_out, 32'h0);
    check("rst mask",  32'(bus_write_mask_out), 32'h0);
    check("rst wval",  bus_write_value_out, 32'h0);
    check("rst i_flt", 32'(instr_fault_out), 32'd0);
    check("rst d_flt", 32'(data_fault_out), 32'd0);
    check("rst i_val", instr_read_value_out, 32'h0);
    check("rst d_val", data_read_value_out, 32'h0);
    step_cycle();
    reset_n = 1'b1;
    step_cycle();

    // Lone instruction fetch, zero wait states
    instr_read_in = 1'b1; instr_address_in = 32'h0000_0100;
    #1 check("t1 idle bus_read", 32'(bus_read_out), 32'd0);
    step_cycle();
    check("t1 bus_read", 32'(bus_read_out), 32'd1);
    check("t1 addr", bus_address_out, 32'h0000_0100);
    check("t1 mask", 32'(bus_write_mask_out), 32'h0);
    bus_ready_in = 1'b1; bus_read_value_in = 32'h0000_0013;
    #1 check("t1 i_ready", 32'(instr_ready_out), 32'd1);
    check("t1 i_val", instr_read_value_out, 32'h0000_0013);
    check("t1 d_ready", 32'(data_ready_out), 32'd0);
    check("t1 d_val", data_read_value_out, 32'h0);
    check("t1 i_flt", 32'(instr_fault_out), 32'd0);
    step_cycle();
    instr_read_in = 1'b0; bus_ready_in = 1'b0;
    #1 check_idle_outputs("t1 after");

    // Simultaneous data write and fetch: write first, fetch after a dead cycle
    step_cycle();
    data_write_in = 1'b1; data_address_in = 32'h0000_2000;
    data_write_mask_in = 4'hF; data_write_value_in = 32'hDEAD_BEEF;
    instr_read_in = 1'b1; instr_address_in = 32'h0000_0104;
    step_cycle();
    check("t2 bus_write", 32'(bus_write_out), 32'd1);
    check("t2 bus_read", 32'(bus_read_out), 32'd0);
    check("t2 addr", bus_address_out, 32'h0000_2000);
    check("t2 mask", 32'(bus_write_mask_out), 32'hF);
    check("t2 wval", bus_write_value_out, 32'hDEAD_BEEF);
    bus_ready_in = 1'b1;
    #1 check("t2 d_ready", 32'(data_ready_out), 32'd1);
    check("t2 i_ready early", 32'(instr_ready_out), 32'd0);
    step_cycle();
    data_write_in = 1'b0; bus_ready_in = 1'b0;
    #1 check_idle_outputs("t2 dead");
    step_cycle();
    check("t2 fetch bus_read", 32'(bus_read_out), 32'd1);
    check("t2 fetch addr", bus_address_out, 32'h0000_0104);
    bus_ready_in = 1'b1; bus_read_value_in = 32'h1122_3344;
    #1 check("t2 i_ready", 32'(instr_ready_out), 32'd1);
    check("t2 i_val", instr_read_value_out, 32'h1122_3344);
    check("t2 d_ready late", 32'(data_ready_out), 32'd0);
    step_cycle();
    instr_read_in = 1'b0; bus_ready_in = 1'b0;
    #1 check_idle_outputs("t2 after");

    // Data read with three wait states, fetch pending and held off
    step_cycle();
    data_read_in = 1'b1; data_address_in = 32'h0000_3000;
    instr_read_in = 1'b1; instr_address_in = 32'h0000_0200;
    bus_read_value_in = 32'hCAFE_F00D;
    for (int k = 1; k <= 4; k++) begin
      step_cycle();
      check($sformatf("t3 c%0d bus_read", k), 32'(bus_read_out), 32'd1);
      check($sformatf("t3 c%0d addr", k), bus_address_out, 32'h0000_3000);
      check($sformatf("t3 c%0d mask", k), 32'(bus_write_mask_out), 32'h0);
      bus_ready_in = (k == 4);
      #1 check($sformatf("t3 c%0d d_ready", k), 32'(data_ready_out), (k == 4) ? 32'd1 : 32'd0);
      check($sformatf("t3 c%0d i_ready", k), 32'(instr_ready_out), 32'd0);
    end
    check("t3 d_val", data_read_value_out, 32'hCAFE_F00D);

    // Fetch granted next, then dropped while the bus waits
    step_cycle();
    data_read_in = 1'b0; bus_ready_in = 1'b0;
    #1 check_idle_outputs("t4 dead");
    step_cycle();
    check("t4 bus_read", 32'(bus_read_out), 32'd1);
    check("t4 addr", bus_address_out, 32'h0000_0200);
    instr_read_in = 1'b0;
    step_cycle();
    check("t4 still busy", 32'(bus_read_out), 32'd1);
    bus_ready_in = 1'b1; bus_read_value_in = 32'h7777_7777;
    #1 check("t4 i_ready", 32'(instr_ready_out), 32'd0);
    check("t4 i_val", instr_read_value_out, 32'h0);
    step_cycle();
    bus_ready_in = 1'b0;
    #1 check_idle_outputs("t4 after");

    // Asynchronous reset during a write
    step_cycle();
    data_write_in = 1'b1; data_address_in = 32'h0000_4000;
    data_write_mask_in = 4'h3; data_write_value_in = 32'h0000_55AA;
    step_cycle();
    check("t5 bus_write", 32'(bus_write_out), 32'd1);
    reset_n = 1'b0;
    #1 check("t5 rst bus_write", 32'(bus_write_out), 32'd0);
    check("t5 rst addr", bus_address_out, 32'h0);
    check("t5 rst mask", 32'(bus_write_mask_out), 32'h0);
    check("t5 rst wval", bus_write_value_out, 32'h0);
    check("t5 rst d_ready", 32'(data_ready_out), 32'd0);
    step_cycle();
    reset_n = 1'b1; data_write_in = 1'b0; bus_ready_in = 1'b1;
    #1 check_idle_outputs("t5 late rdy");
    step_cycle();
    bus_ready_in = 1'b0;
    #1 check_idle_outputs("t5 after");

    // Slave that never answers
    step_cycle();
    data_read_in = 1'b1; data_address_in = 32'h0000_5000;
    bus_read_value_in = 32'h9999_9999;
`ifdef RV32_BUS_TIMEOUT_EN
    for (int k = 1; k <= 5; k++) begin
      step_cycle();
      #1 check($sformatf("t6 c%0d d_ready", k), 32'(data_ready_out), (k == 5) ? 32'd1 : 32'd0);
      check($sformatf("t6 c%0d d_flt", k), 32'(data_fault_out), (k == 5) ? 32'd1 : 32'd0);
      check($sformatf("t6 c%0d d_val", k), data_read_value_out, 32'h0);
    end
    step_cycle();
    data_read_in = 1'b0;
    #1 check_idle_outputs("t6 after");
`else
    for (int k = 1; k <= 8; k++) begin
      step_cycle();
      #1 check($sformatf("t6 c%0d d_ready", k), 32'(data_ready_out), 32'd0);
      check($sformatf("t6 c%0d d_flt", k), 32'(data_fault_out), 32'd0);
      check($sformatf("t6 c%0d bus_read", k), 32'(bus_read_out), 32'd1);
    end
    step_cycle();
    bus_ready_in = 1'b1;
    #1 check("t6 late d_ready", 32'(data_ready_out), 32'd1);
    check("t6 late d_flt", 32'(data_fault_out), 32'd0);
    check("t6 late d_val", data_read_value_out, 32'h9999_9999);
    step_cycle();
    data_read_in = 1'b0; bus_ready_in = 1'b0;
    #1 check_idle_outputs("t6 after");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
